mul_hilo_seq: RTL

Multicycle sequencer and HI/LO register file placed directly around the team's combinational 32x32 signed bit-pair Booth multiplier.
- Registers the operands onto the multiplier inputs and waits a fixed settle window, so the long combinational path is a declared multicycle path.
- Captures the 64-bit product into the HI/LO architectural registers and signals completion to the control unit.
- Also services direct HI/LO writes (move-to-HI/LO) from the datapath.

---
 rtl/mul_hilo_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mul_hilo_seq.sv
// Multicycle launch/capture sequencer and HI/LO registers around an external combinational signed multiplier.
// Result lands SETTLE_CYCLES edges after start; start during WAIT is dropped; optional ovf flag under MUL_OVF_FLAG_EN.
module mul_hilo_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int WIDTH         = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_z,
    output logic               busy,
    output logic               done,
    input  logic               hi_wr,
    input  logic               lo_wr,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic               ovf
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   prod_hi;
    logic [WIDTH-1:0]   prod_lo;

    assign prod_hi = mul_z[2*WIDTH-1:WIDTH];
    assign prod_lo = mul_z[WIDTH-1:0];

`ifdef MUL_OVF_FLAG_EN
    logic ovf_q, ovf_d;
    logic prod_ovf;

    // Product fits in WIDTH signed bits only when the upper half is pure sign extension.
    assign prod_ovf = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MUL_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (hi_wr) begin
                    hi_d = wr_data;
                end
                if (lo_wr) begin
                    lo_d = wr_data;
                end
`ifdef MUL_OVF_FLAG_EN
                if (hi_wr || lo_wr) begin
                    ovf_d = 1'b0;
                end
`endif
                if (start) begin
                    mul_a_d = op_a;
                    mul_b_d = op_b;
                    cnt_d   = SETTLE_INIT;
                    state_d = ST_WAIT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_WAIT: begin
                // HI/LO belong to the pending capture; start and direct writes are ignored here.
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    hi_d    = prod_hi;
                    lo_d    = prod_lo;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef MUL_OVF_FLAG_EN
                    ovf_d   = prod_ovf;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef MUL_OVF_FLAG_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
